dbp_param: RTL and testbench

Parametrised dynamic branch predictor for the fetch stage: a table of saturating direction counters (the BHT) plus a tagged, valid-qualified branch target buffer (the BTB). The table index is either bimodal (PC bits only) or gshare (PC XOR a speculative global history register), with history recovery on a misprediction. It sits between the PC register and the decode-stage resolution logic. Lookup is combinational from the fetch PC, and updates arrive from decode.

---
 rtl/dbp_pkg.sv | 30 +++
 rtl/dbp_table.sv | 35 +++
 rtl/dbp_param.sv | 100 ++++++++++
 tb/tb_dbp_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dbp_pkg.sv
// Shared helpers for the branch predictor: counter reset value, saturating
// counter arithmetic and the BHT/BTB index hash.
package dbp_pkg;

  function automatic logic [31:0] ctr_rst(input int ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_w);
    logic [31:0] top;
    top = (32'd1 << ctr_w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  // PC is halfword aligned, so bit 0 never contributes to the index.
  function automatic logic [31:0] dbp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                            input int idx_w, input bit gshare);
    logic [31:0] mask;
    logic [31:0] idx;
    mask = (32'd1 << idx_w) - 32'd1;
    idx  = (pc >> 1) & mask;
    if (gshare) idx = idx ^ (ghr & mask);
    return idx;
  endfunction

endpackage

// File: rtl/dbp_table.sv
// Generic 2^IDX_W x W register array: NRD combinational read ports, one
// synchronous write port, async active-low reset to RST_VAL.
module dbp_table #(
  parameter int             IDX_W   = 4,
  parameter int             W       = 2,
  parameter int             NRD     = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD-1:0][IDX_W-1:0] raddr,
  output logic [NRD-1:0][W-1:0]     rdata,
  input  logic                      we,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [W-1:0]              wdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old contents.
  always_comb begin
    for (int r = 0; r < NRD; r++) rdata[r] = mem[raddr[r]];
  end

endmodule

// File: rtl/dbp_param.sv
// Dynamic branch predictor: saturating-counter BHT plus tagged BTB, indexed
// bimodally or by gshare, with a speculative GHR restored on mispredict.
module dbp_param
  import dbp_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int TAG_W  = 6,
  parameter int GHR_W  = 4,
  parameter int GSHARE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] PC_curr,
  output logic [CTR_W-1:0]  prediction,
  output logic [ADDR_W-1:0] predicted_target,
  output logic              btb_hit,
  output logic              predict_taken,
  output logic [GHR_W-1:0]  ghr_snapshot,
  input  logic [ADDR_W-1:0] upd_PC,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              wen_BHT,
  input  logic              wen_BTB,
  input  logic              upd_mispredict
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  localparam int BTB_W = $bits(btb_entry_t);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst(CTR_W));

  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] look_idx, upd_idx;

  logic [1:0][IDX_W-1:0] bht_raddr;
  logic [1:0][CTR_W-1:0] bht_rdata;
  logic [CTR_W-1:0]      bht_wdata;

  logic [0:0][IDX_W-1:0] btb_raddr;
  logic [0:0][BTB_W-1:0] btb_rdata;
  btb_entry_t            btb_rd, btb_wr;

  assign look_idx = IDX_W'(dbp_index(32'(PC_curr), 32'(ghr), IDX_W, GSHARE != 0));
  assign upd_idx  = IDX_W'(dbp_index(32'(upd_PC), 32'(upd_ghr), IDX_W, GSHARE != 0));

  // Port 0 serves the fetch lookup, port 1 reads the counter being trained.
  assign bht_raddr = {upd_idx, look_idx};
  assign bht_wdata = upd_taken ? CTR_W'(sat_inc(32'(bht_rdata[1]), CTR_W))
                               : CTR_W'(sat_dec(32'(bht_rdata[1])));

  dbp_table #(.IDX_W(IDX_W), .W(CTR_W), .NRD(2), .RST_VAL(CTR_RST)) u_bht (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (bht_raddr),
    .rdata (bht_rdata),
    .we    (wen_BHT),
    .waddr (upd_idx),
    .wdata (bht_wdata)
  );

  assign btb_raddr[0] = look_idx;
  assign btb_rd       = btb_rdata[0];
  assign btb_wr       = '{valid: 1'b1, tag: upd_PC[IDX_W+TAG_W:IDX_W+1], target: upd_target};

  dbp_table #(.IDX_W(IDX_W), .W(BTB_W), .NRD(1), .RST_VAL('0)) u_btb (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (btb_raddr),
    .rdata (btb_rdata),
    .we    (wen_BTB),
    .waddr (upd_idx),
    .wdata (btb_wr)
  );

  assign btb_hit          = btb_rd.valid && (btb_rd.tag == PC_curr[IDX_W+TAG_W:IDX_W+1]);
  assign predicted_target = btb_hit ? btb_rd.target : '0;
  assign prediction       = bht_rdata[0];
  assign predict_taken    = prediction[CTR_W-1] & btb_hit;
  assign ghr_snapshot     = ghr;

  // Recovery wins over the speculative shift; the cast keeps the low GHR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_mispredict) begin
      ghr <= GHR_W'({upd_ghr, upd_taken});
    end else if (enable && btb_hit) begin
      ghr <= GHR_W'({ghr, predict_taken});
    end
  end

endmodule

// File: tb/tb_dbp_param.sv
// Directed bench: a bimodal and a gshare instance share one stimulus stream.
module tb_dbp_param;

  logic        clk, rst_n, enable;
  logic [15:0] PC_curr, upd_PC, upd_target;
  logic [3:0]  upd_ghr;
  logic        upd_taken, wen_BHT, wen_BTB, upd_mispredict;

  logic [1:0]  b_pred, g_pred;
  logic [15:0] b_tgt, g_tgt;
  logic        b_hit, g_hit, b_tk, g_tk;
  logic [3:0]  b_ghr, g_ghr;

  int total = 0;
  int bad   = 0;

  dbp_param #(.GSHARE(0)) u_bim (
    .clk(clk), .rst_n(rst_n), .enable(enable), .PC_curr(PC_curr),
    .prediction(b_pred), .predicted_target(b_tgt), .btb_hit(b_hit),
    .predict_taken(b_tk), .ghr_snapshot(b_ghr),
    .upd_PC(upd_PC), .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
    .wen_BHT(wen_BHT), .wen_BTB(wen_BTB), .upd_mispredict(upd_mispredict)
  );

  dbp_param #(.GSHARE(1)) u_gsh (
    .clk(clk), .rst_n(rst_n), .enable(enable), .PC_curr(PC_curr),
    .prediction(g_pred), .predicted_target(g_tgt), .btb_hit(g_hit),
    .predict_taken(g_tk), .ghr_snapshot(g_ghr),
    .upd_PC(upd_PC), .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_target(upd_target),
    .wen_BHT(wen_BHT), .wen_BTB(wen_BTB), .upd_mispredict(upd_mispredict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; PC_curr = 16'h0010;
    upd_PC = '0; upd_ghr = '0; upd_taken = 1'b0; upd_target = '0;
    wen_BHT = 1'b0; wen_BTB = 1'b0; upd_mispredict = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pred", b_pred, 2'b01);
    chk("rst_hit", b_hit, 1'b0);
    chk("rst_tgt", b_tgt, 16'h0);
    chk("rst_ghr", g_ghr, 4'h0);
    chk("rst_tk", g_tk, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // counter saturation at PC 0x0004
    PC_curr = 16'h0004; upd_PC = 16'h0004; upd_taken = 1'b1; wen_BHT = 1'b1;
    #1 chk("sat_init", b_pred, 2'b01);
    step(); chk("sat_inc1", b_pred, 2'b10);
    step(); chk("sat_inc2", b_pred, 2'b11);
    step(); chk("sat_inc3", b_pred, 2'b11);
    upd_taken = 1'b0;
    step(); chk("sat_dec1", b_pred, 2'b10);
    step(); chk("sat_dec2", b_pred, 2'b01);
    step(); chk("sat_dec3", b_pred, 2'b00);
    step(); chk("sat_dec4", b_pred, 2'b00);
    wen_BHT = 1'b0;

    // BTB write and tag alias
    upd_PC = 16'h0002; upd_target = 16'h1234; wen_BTB = 1'b1;
    PC_curr = 16'h0002;
    #1 chk("btb_pre_hit", b_hit, 1'b0);
    step(); wen_BTB = 1'b0;
    #1;
    chk("btb_hit", b_hit, 1'b1);
    chk("btb_tgt", b_tgt, 16'h1234);
    chk("btb_tk_weak", b_tk, 1'b0);
    PC_curr = 16'h0022;
    #1;
    chk("alias_hit", b_hit, 1'b0);
    chk("alias_tk", b_tk, 1'b0);
    chk("alias_tgt", b_tgt, 16'h0);

    // read/write collision at PC 0x0006
    PC_curr = 16'h0006; upd_PC = 16'h0006; upd_taken = 1'b1; wen_BHT = 1'b1;
    #1 chk("coll_old", b_pred, 2'b01);
    step(); wen_BHT = 1'b0;
    #1 chk("coll_new", b_pred, 2'b10);

    // train gshare entries at indices 1, 0, 2 (PC 0x0002 with ghr 0, 1, 3)
    upd_PC = 16'h0002; upd_target = 16'h1234; upd_taken = 1'b1;
    wen_BHT = 1'b1; wen_BTB = 1'b1;
    upd_ghr = 4'h0; step();
    upd_ghr = 4'h1; step();
    upd_ghr = 4'h3; step(); step();
    wen_BHT = 1'b0; wen_BTB = 1'b0;

    PC_curr = 16'h0002; enable = 1'b1;
    #1;
    chk("gs_ghr0", g_ghr, 4'h0);
    chk("gs_tk0", g_tk, 1'b1);
    step(); chk("gs_ghr1", g_ghr, 4'h1); chk("gs_tk1", g_tk, 1'b1);
    step(); chk("gs_ghr3", g_ghr, 4'h3); chk("gs_tk3", g_tk, 1'b1);
    step(); chk("gs_ghr7", g_ghr, 4'h7);
    // index 7^7 = 0 hits, so a speculative shift would be eligible this cycle
    PC_curr = 16'h000E; upd_mispredict = 1'b1; upd_ghr = 4'h1; upd_taken = 1'b0;
    #1 chk("gs_shift_elig", g_tk, 1'b1);
    step(); upd_mispredict = 1'b0; enable = 1'b0;
    chk("gs_recover", g_ghr, 4'h2);
    step(); chk("gs_stall_hold", g_ghr, 4'h2);

    // asynchronous reset between edges
    PC_curr = 16'h0002;
    #1;
    chk("mid_hit_pre", b_hit, 1'b1);
    chk("mid_pred_pre", b_pred, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_hit", b_hit, 1'b0);
    chk("mid_tgt", b_tgt, 16'h0);
    chk("mid_pred", b_pred, 2'b01);
    chk("mid_ghr", g_ghr, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
